fluid_in_queue: RTL and testbench

FLUID_IN_QUEUE -- requirements
Module: fluid_in_queue

---
 rtl/fluid_in_queue.sv | 94 +++++++++
 tb/tb_fluid_in_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/fluid_in_queue.sv
// fluid_in_queue: circular-buffer FIFO between an upstream producer and the
// downstream fluid pipeline. Both channels use valid/stop handshakes. A token
// moves on a channel in any cycle where valid=1 and stop=0 at posedge clk.
//
// Optional feature: define FLUID_QUEUE_BYPASS_EN to compile a zero-latency
// bypass. An empty queue then presents an incoming token on the output in
// the same cycle. The default build has no bypass, so the outputs come from
// registered state only.
//
// Ports:
//   clk        sole clock; all state updates on posedge
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers in_data
//   in_data    upstream payload {in3,in2,in1}
//   in_stop    upstream must hold; registered (queue full)
//   out_valid  out_data holds a valid token
//   out_data   head-of-queue payload; holds the last value while empty
//   out_stop   downstream cannot accept this cycle
//   count      entries currently stored
module fluid_in_queue #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_stop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_stop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             full, empty;
  logic             bypass, byp_thru;
  logic             push, pop, wr_en, rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // in_stop depends only on the registered count, never on out_stop.
  assign in_stop = full;
  assign count   = cnt;

`ifdef FLUID_QUEUE_BYPASS_EN
  // Gated by rst_n so that the outputs stay quiet while reset is asserted.
  assign bypass = empty & in_valid & rst_n;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = ~empty | bypass;
    if (bypass)      out_data = in_data;
    else if (empty)  out_data = hold;
    else             out_data = mem[rd_ptr];
  end

  assign push     = rst_n & in_valid & ~full;
  assign pop      = rst_n & out_valid & ~out_stop;
  // A bypassed token that leaves at once is never written. A stalled one is
  // written normally, so the queue then holds it (count becomes 1).
  assign byp_thru = bypass & ~out_stop;
  assign wr_en    = push & ~byp_thru;
  assign rd_en    = pop & ~bypass;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // The pointers are AW bits wide over a power-of-two depth, so they wrap
  // from DEPTH-1 to 0 without extra logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
      // Keep the token that just left, so out_data holds it once empty.
      if (pop) hold <= out_data;
    end
  end
endmodule

// File: tb/tb_fluid_in_queue.sv
// Scoreboard bench for fluid_in_queue in the default build (no bypass).
// The stimulus process pushes the tokens it expects the queue to accept.
// The monitor process samples the DUT late in each cycle and checks it
// against the expected queue. It pops the queue on each output handshake.
module tb_fluid_in_queue;
  localparam int WIDTH = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_stop;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_stop = 1'b0;
  logic [$clog2(DEPTH):0] count;

  fluid_in_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_stop(in_stop), .out_valid(out_valid), .out_data(out_data),
    .out_stop(out_stop), .count(count)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_out = '0;
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples 3 time units after the negedge. That is after the
  // stimulus settles and well before the next posedge.
  initial begin
    forever begin
      @(negedge clk); #3;
      chk("count", int'(count), exp_q.size());
      chk("in_stop", int'(in_stop), int'(exp_q.size() == DEPTH));
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() == 0) chk("out_data_hold", int'(out_data), int'(last_out));
      if (!rst_n) begin
        exp_q.delete();
        last_out = '0;
      end else if (out_valid && !out_stop) begin
        if (exp_q.size() == 0) begin
          chk("pop_on_empty", 1, 0);
        end else begin
          last_out = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(last_out));
        end
      end
    end
  end

  // One cycle of stimulus. The model accepts a token when the queue is not
  // full at the start of the cycle, because in_stop comes from stored state.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic s,
                     input logic r);
    logic acc;
    @(negedge clk); #1;
    in_valid = v; in_data = d; out_stop = s; rst_n = r;
    acc = r && v && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (acc) exp_q.push_back(d);
  endtask

  initial begin
    // Reset for 2 cycles while in_valid is high.
    cyc(1, 3'b110, 0, 0);
    cyc(1, 3'b101, 0, 0);
    cyc(0, 0, 0, 1);
    // Fill under backpressure. The 5th push is ignored.
    cyc(1, 3'b001, 1, 1);
    cyc(1, 3'b010, 1, 1);
    cyc(1, 3'b011, 1, 1);
    cyc(1, 3'b100, 1, 1);
    cyc(1, 3'b111, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    // Wrap: continuous push/pop of 0..7,0,1.
    for (int i = 0; i < 10; i++) cyc(1, WIDTH'(i % 8), 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    // Full-pop: pop while full, so no push that cycle. The next push is accepted.
    for (int i = 0; i < 4; i++) cyc(1, WIDTH'(i + 2), 1, 1);
    cyc(1, 3'b101, 0, 1);
    cyc(1, 3'b110, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    // Backpressure hold, then reset on the 3rd stalled cycle.
    cyc(1, 3'b011, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    // Random traffic with an occasional reset.
    for (int i = 0; i < 400; i++)
      cyc(logic'($urandom_range(0, 99) < 60), WIDTH'($urandom),
          logic'($urandom_range(0, 99) < 40), logic'($urandom_range(0, 99) != 0));
    // Drain.
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1);
    @(negedge clk); #4;
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
